// File: rtl/avr_imem_server.sv
// ---------------------------------------------------------------------------
// avr_imem_server
//   Instruction-side responder for the AVR core. Holds a loadable program RAM,
//   answers each core fetch address with a registered 16-bit instruction word
//   and sequences IDLE -> RUN -> HALT. core_run tells the core when it may
//   advance.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   load_en      write load_data to mem[load_addr] (ignored while running)
//   load_addr    program write address
//   load_data    program write data
//   start        one-cycle pulse: begin a run from IDLE or HALT
//   pc           fetch address from the core
//   instruction  registered instruction word (1-cycle latency from pc)
//   core_run     high while state is RUN
//   halted       set when the BREAK opcode is fetched, cleared by start
//   pc_err       sticky out-of-range fetch flag, cleared by start
//   fetch_count  words delivered in the current run, saturating
//   state        00 IDLE, 01 RUN, 10 HALT
// ---------------------------------------------------------------------------
module avr_imem_server #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter logic [15:0] HALT_OPCODE = 16'h9598,
  parameter logic [15:0] NOP_OPCODE  = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  output logic [15:0]       instruction,
  output logic              core_run,
  output logic              halted,
  output logic              pc_err,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state
);

  localparam int unsigned WORD_W = 16;
  // Compare width wide enough to hold both pc and DEPTH without truncation
  localparam int unsigned CMP_W  = ((PC_W > ADDR_W) ? PC_W : ADDR_W) + 1;
  localparam logic [WORD_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   instr_d;
  logic                halted_d;
  logic                pc_err_d;
  logic [WORD_W-1:0]   count_d;
  logic                mem_we;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   pc_idx;
  logic                pc_in_range;
  logic [WORD_W-1:0]   fetch_word;

  // Fetch address decode; fetch_word is only used when pc is in range
  assign pc_idx      = ADDR_W'(pc);
  assign pc_in_range = (CMP_W'(pc) < CMP_W'(DEPTH));
  assign fetch_word  = mem[pc_idx];

  // Program RAM: no reset, contents survive a reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    instr_d  = NOP_OPCODE;
    halted_d = halted;
    pc_err_d = pc_err;
    count_d  = fetch_count;
    mem_we   = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Every RUN edge delivers one word, in range or not
        if (fetch_count != CNT_MAX) begin
          count_d = fetch_count + WORD_W'(1);
        end
        if (pc_in_range) begin
          instr_d = fetch_word;
          if (fetch_word == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        end else begin
          pc_err_d = 1'b1;
        end
      end
      default: begin
        // IDLE, HALT and the unused encoding all behave as stopped states;
        // a load coinciding with start lands before the first RUN fetch
        mem_we = load_en;
        if (start) begin
          state_d  = ST_RUN;
          count_d  = '0;
          halted_d = 1'b0;
          pc_err_d = 1'b0;
        end
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_OPCODE;
      halted      <= 1'b0;
      pc_err      <= 1'b0;
      fetch_count <= '0;
    end else begin
      instruction <= instr_d;
      halted      <= halted_d;
      pc_err      <= pc_err_d;
      fetch_count <= count_d;
    end
  end

  assign state    = 2'(state_q);
  assign core_run = (state_q == ST_RUN);

endmodule

// File: tb/tb_avr_imem_server.sv
// ---------------------------------------------------------------------------
// tb_avr_imem_server
//   Directed bench for avr_imem_server. Expected instruction words come from a
//   bench-side copy of the program and are queued when a pc is driven, then
//   popped and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_avr_imem_server;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned ADDR_W = 7;

  logic              clk;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              start;
  logic [PC_W-1:0]   pc;
  logic [15:0]       instruction;
  logic              core_run;
  logic              halted;
  logic              pc_err;
  logic [15:0]       fetch_count;
  logic [1:0]        state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q [$];

  avr_imem_server dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .core_run    (core_run),
    .halted      (halted),
    .pc_err      (pc_err),
    .fetch_count (fetch_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pc during RUN; the expected word is derived from the model
  task automatic fetch(input logic [PC_W-1:0] p, input string tag);
    logic [15:0] e;
    pc = p;
    exp_q.push_back((32'(p) < DEPTH) ? model_mem[7'(p)] : 16'h0000);
    tick();
    e = exp_q.pop_front();
    chk(tag, instruction, e);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model_mem[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; pc = '0;

    // 1: reset values visible before any clock edge
    #3;
    chk("rst_state", 16'(state), 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_run",   16'(core_run), 16'h0000);
    chk("rst_halt",  16'(halted), 16'h0000);
    chk("rst_perr",  16'(pc_err), 16'h0000);
    chk("rst_cnt",   fetch_count, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 2: load a 3-word program and run to BREAK
    load(7'd0, 16'h0C01);
    load(7'd1, 16'h1C02);
    load(7'd2, 16'h9598);
    chk("idle_instr", instruction, 16'h0000);
    pulse_start();
    chk("run_state", 16'(state), 16'h0001);
    chk("run_core",  16'(core_run), 16'h0001);
    fetch(8'd0, "f0");
    chk("cnt1", fetch_count, 16'd1);
    fetch(8'd1, "f1");
    fetch(8'd2, "f2_break");
    chk("halt_state", 16'(state), 16'h0002);
    chk("halt_flag",  16'(halted), 16'h0001);
    chk("halt_core",  16'(core_run), 16'h0000);
    chk("halt_cnt",   fetch_count, 16'd3);
    pc = 8'd0;
    tick();
    chk("halt_nop", instruction, 16'h0000);

    // 3: out-of-range pc is sticky but does not stop the run
    pulse_start();
    chk("restart_halted", 16'(halted), 16'h0000);
    chk("restart_cnt",    fetch_count, 16'h0000);
    fetch(8'd128, "oor128");
    chk("perr128", 16'(pc_err), 16'h0001);
    fetch(8'd200, "oor200");
    chk("perr200", 16'(pc_err), 16'h0001);
    fetch(8'd0, "after_oor");
    chk("perr_sticky", 16'(pc_err), 16'h0001);
    chk("oor_state",   16'(state), 16'h0001);
    chk("oor_cnt",     fetch_count, 16'd3);

    // 4: loads during RUN are ignored (model left untouched)
    load_en = 1'b1; load_addr = 7'd0; load_data = 16'hFFFF;
    fetch(8'd1, "run_load");
    load_en = 1'b0;
    fetch(8'd2, "run_load_break");
    chk("run_load_halt", 16'(state), 16'h0002);
    pulse_start();
    chk("start_clr_perr", 16'(pc_err), 16'h0000);
    fetch(8'd0, "ram_kept");
    chk("ram_kept_cnt", fetch_count, 16'd1);

    // start while running is ignored
    start = 1'b1;
    fetch(8'd1, "start_in_run");
    start = 1'b0;
    chk("start_in_run_cnt", fetch_count, 16'd2);

    // 5: async reset mid-RUN, RAM retained
    fetch(8'd0, "pre_rst0");
    fetch(8'd1, "pre_rst1");
    fetch(8'd0, "pre_rst2");
    chk("pre_rst_cnt", fetch_count, 16'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 16'(state), 16'h0000);
    chk("mid_rst_cnt",   fetch_count, 16'h0000);
    chk("mid_rst_core",  16'(core_run), 16'h0000);
    chk("mid_rst_instr", instruction, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    fetch(8'd0, "post_rst0");
    fetch(8'd1, "post_rst1");
    fetch(8'd2, "post_rst2");
    chk("post_rst_halt", 16'(halted), 16'h0001);

    // 6: load and start on the same edge from IDLE
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1;
    load(7'd0, 16'h2C34);
    start = 1'b0;
    fetch(8'd0, "ld_start");
    chk("ld_start_cnt", fetch_count, 16'd1);

    // fetch_count saturates at FFFF
    pc = 8'd200;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_cnt", fetch_count, 16'hFFFF);
    tick();
    chk("sat_hold", fetch_count, 16'hFFFF);
    chk("sat_state", 16'(state), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
